// File: rtl/decode_issue_pkg.sv
// decode_issue_pkg: shared types and opcode constants for the decode/issue stage
package decode_issue_pkg;
  localparam int XLEN_W = 32;
  typedef logic [4:0] reg_addr_t;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  typedef struct packed {
    logic [XLEN_W-1:0] pc;
    logic [XLEN_W-1:0] inst;
  } decode_stage_pipe_reg_t;
  typedef struct packed {
    logic              valid;
    logic [XLEN_W-1:0] pc;
    logic [XLEN_W-1:0] inst;
    reg_addr_t         rs1;
    reg_addr_t         rs2;
    reg_addr_t         rd;
    logic              rd_we;
  } issued_op_t;
endpackage

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: shift register of in-flight destination registers and RAW hazard compare
module issue_scoreboard
  import decode_issue_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push_valid,
  input  reg_addr_t push_rd,
  input  reg_addr_t rs1,
  input  reg_addr_t rs2,
  input  logic      use_rs1,
  input  logic      use_rs2,
  output logic      hazard
);
  logic [DEPTH-1:0] sb_valid;
  reg_addr_t        sb_rd [DEPTH];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_valid <= '0;
      for (int i = 0; i < DEPTH; i++) sb_rd[i] <= '0;
    end else begin
      sb_valid[0] <= push_valid;
      sb_rd[0]    <= push_rd;
      for (int i = 1; i < DEPTH; i++) begin
        sb_valid[i] <= sb_valid[i-1];
        sb_rd[i]    <= sb_rd[i-1];
      end
    end
  end
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (sb_valid[i] && ((use_rs1 && rs1 != '0 && sb_rd[i] == rs1) || (use_rs2 && rs2 != '0 && sb_rd[i] == rs2)))
        hazard = 1'b1;
  end
endmodule

// File: rtl/decode_issue.sv
// decode_issue: fetch-to-decode pipe register, field decode and stall-on-RAW issue
module decode_issue
  import decode_issue_pkg::*;
#(
  parameter int PIPE_DEPTH = 3,
  parameter int XLEN       = XLEN_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] fetch_pc,
  input  logic [XLEN-1:0] fetch_inst,
  output logic            is_data_hazard,
  output logic            dec_valid,
  output logic [XLEN-1:0] dec_pc,
  output logic [XLEN-1:0] dec_inst,
  output logic [4:0]      dec_rs1,
  output logic [4:0]      dec_rs2,
  output logic [4:0]      dec_rd,
  output logic            dec_rd_we
);
  function automatic logic reads_rs1(input logic [XLEN_W-1:0] inst);
    return inst != '0 && !(inst[6:0] inside {OP_LUI, OP_AUIPC, OP_JAL});
  endfunction
  function automatic logic reads_rs2(input logic [XLEN_W-1:0] inst);
    return inst != '0 && inst[6:0] inside {OP_R, OP_S, OP_B};
  endfunction
  function automatic logic writes_rd(input logic [XLEN_W-1:0] inst);
    return inst != '0 && !(inst[6:0] inside {OP_S, OP_B}) && inst[11:7] != '0;
  endfunction
  function automatic issued_op_t decode(input logic [XLEN_W-1:0] pc, input logic [XLEN_W-1:0] inst);
    issued_op_t d;
    d.valid = inst != '0;
    d.pc    = pc;
    d.inst  = inst;
    d.rs1   = reads_rs1(inst) ? inst[19:15] : '0;
    d.rs2   = reads_rs2(inst) ? inst[24:20] : '0;
    d.rd_we = writes_rd(inst);
    d.rd    = d.rd_we ? inst[11:7] : '0;
    return d;
  endfunction
  decode_stage_pipe_reg_t in_r;
  issued_op_t             cur;
  issued_op_t             dec;
  assign cur = decode(in_r.pc, in_r.inst);
  issue_scoreboard #(.DEPTH(PIPE_DEPTH)) u_sb (
    .clk        (clk),
    .rst        (rst),
    .push_valid (!is_data_hazard && cur.rd_we),
    .push_rd    (cur.rd),
    .rs1        (cur.rs1),
    .rs2        (cur.rs2),
    .use_rs1    (reads_rs1(in_r.inst)),
    .use_rs2    (reads_rs2(in_r.inst)),
    .hazard     (is_data_hazard)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_r <= '0;
      dec  <= '0;
    end else if (is_data_hazard) begin
      dec <= '0;
    end else begin
      dec  <= cur;
      in_r <= '{pc: fetch_pc, inst: fetch_inst};
    end
  end
  assign dec_valid = dec.valid;
  assign dec_pc    = dec.pc;
  assign dec_inst  = dec.inst;
  assign dec_rs1   = dec.rs1;
  assign dec_rs2   = dec.rs2;
  assign dec_rd    = dec.rd;
  assign dec_rd_we = dec.rd_we;
endmodule

// File: tb/tb_decode_issue.sv
// tb_decode_issue: directed table-driven check of decode, issue and RAW stalls
module tb_decode_issue;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_inst;
  logic        is_data_hazard;
  logic        dec_valid;
  logic [31:0] dec_pc;
  logic [31:0] dec_inst;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [4:0]  dec_rd;
  logic        dec_rd_we;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        hz;
    logic        v;
    logic [31:0] epc;
    logic [31:0] einst;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        we;
  } vec_t;
  vec_t tbl[$];
  decode_issue #(.PIPE_DEPTH(3), .XLEN(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_pc       (fetch_pc),
    .fetch_inst     (fetch_inst),
    .is_data_hazard (is_data_hazard),
    .dec_valid      (dec_valid),
    .dec_pc         (dec_pc),
    .dec_inst       (dec_inst),
    .dec_rs1        (dec_rs1),
    .dec_rs2        (dec_rs2),
    .dec_rd         (dec_rd),
    .dec_rd_we      (dec_rd_we)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  function automatic vec_t mk(input logic [31:0] pc, input logic [31:0] inst, input logic hz, input logic v,
                              input logic [31:0] epc, input logic [31:0] einst, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [4:0] rd, input logic we);
    vec_t t;
    t.pc = pc; t.inst = inst; t.hz = hz; t.v = v; t.epc = epc; t.einst = einst;
    t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.we = we;
    return t;
  endfunction
  function automatic vec_t idle(input logic [31:0] pc, input logic [31:0] inst, input logic hz);
    return mk(pc, inst, hz, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  initial begin
    // back-to-back RAW: addi x1 ; add x2,x1,x1
    tbl.push_back(idle(0, 32'h00500093, 0));
    tbl.push_back(idle(4, 32'h00108133, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 32'h00500093, 0, 0, 1, 1));
    tbl.push_back(idle(0, 0, 1));
    tbl.push_back(idle(0, 0, 1));
    tbl.push_back(idle(0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 4, 32'h00108133, 1, 1, 2, 1));
    // independent stream: addi x1 ; addi x3
    tbl.push_back(idle(0, 32'h00500093, 0));
    tbl.push_back(idle(4, 32'h00700193, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 32'h00500093, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 1, 4, 32'h00700193, 0, 0, 3, 1));
    // x0 writer, add x5,x0,x0, lui with rs1-field=5, jal x0 with rs1-field=1
    tbl.push_back(idle(8, 32'h00000013, 0));
    tbl.push_back(idle(12, 32'h000002b3, 0));
    tbl.push_back(mk(16, 32'h000280b7, 0, 1, 8, 32'h00000013, 0, 0, 0, 0));
    tbl.push_back(mk(20, 32'h0000806f, 0, 1, 12, 32'h000002b3, 0, 0, 5, 1));
    tbl.push_back(mk(0, 0, 0, 1, 16, 32'h000280b7, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 1, 20, 32'h0000806f, 0, 0, 0, 0));
    // distance 2 NOPs: one hazard cycle
    tbl.push_back(idle(0, 32'h00500093, 0));
    tbl.push_back(idle(0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 32'h00500093, 0, 0, 1, 1));
    tbl.push_back(idle(4, 32'h00108133, 0));
    tbl.push_back(idle(0, 0, 1));
    tbl.push_back(idle(0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 4, 32'h00108133, 1, 1, 2, 1));
    // distance 3 NOPs: no hazard
    tbl.push_back(idle(0, 32'h00500093, 0));
    tbl.push_back(idle(0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 32'h00500093, 0, 0, 1, 1));
    tbl.push_back(idle(0, 0, 0));
    tbl.push_back(idle(4, 32'h00108133, 0));
    tbl.push_back(idle(0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 4, 32'h00108133, 1, 1, 2, 1));
    // addi x2 ; sw x1,4(x2) ; add x3,x4,x4 (sw must not enter x4)
    tbl.push_back(idle(0, 32'h00500113, 0));
    tbl.push_back(idle(4, 32'h00112223, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 32'h00500113, 0, 0, 2, 1));
    tbl.push_back(idle(0, 0, 1));
    tbl.push_back(idle(0, 0, 1));
    tbl.push_back(idle(8, 32'h004201b3, 0));
    tbl.push_back(mk(0, 0, 0, 1, 4, 32'h00112223, 2, 1, 0, 0));
    // beq x3,x3 at distance 2 from add x3: rs1==rs2 single hazard
    tbl.push_back(mk(12, 32'h00318063, 0, 1, 8, 32'h004201b3, 4, 4, 3, 1));
    tbl.push_back(idle(0, 0, 1));
    tbl.push_back(idle(0, 0, 1));
    tbl.push_back(idle(0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 12, 32'h00318063, 3, 3, 0, 0));
    // two producers: stall ends when the younger x2 retires
    tbl.push_back(idle(0, 32'h00500093, 0));
    tbl.push_back(idle(4, 32'h00500113, 0));
    tbl.push_back(mk(8, 32'h002081b3, 0, 1, 0, 32'h00500093, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 1, 1, 4, 32'h00500113, 0, 0, 2, 1));
    tbl.push_back(idle(0, 0, 1));
    tbl.push_back(idle(0, 0, 1));
    tbl.push_back(idle(0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 8, 32'h002081b3, 1, 2, 3, 1));
    // reset behaviour
    rst = 1'b0;
    fetch_pc = 0;
    fetch_inst = 32'h00108133;
    repeat (2) @(negedge clk);
    #1;
    chk("reset dec_valid", dec_valid, 0);
    chk("reset hazard", is_data_hazard, 0);
    chk("reset dec_inst", dec_inst, 0);
    rst = 1'b1;
    @(negedge clk);
    fetch_inst = 0;
    #1;
    chk("post-reset edge1 dec_valid", dec_valid, 0);
    chk("post-reset edge1 hazard", is_data_hazard, 0);
    @(negedge clk);
    #1;
    chk("post-reset edge2 dec_valid", dec_valid, 1);
    chk("post-reset edge2 dec_rd", dec_rd, 2);
    chk("post-reset edge2 dec_inst", dec_inst, 32'h00108133);
    repeat (3) @(posedge clk);
    foreach (tbl[i]) begin
      @(negedge clk);
      fetch_pc = tbl[i].pc;
      fetch_inst = tbl[i].inst;
      #1;
      chk($sformatf("r%0d hazard", i), is_data_hazard, tbl[i].hz);
      chk($sformatf("r%0d dec_valid", i), dec_valid, tbl[i].v);
      chk($sformatf("r%0d dec_pc", i), dec_pc, tbl[i].epc);
      chk($sformatf("r%0d dec_inst", i), dec_inst, tbl[i].einst);
      chk($sformatf("r%0d dec_rs1", i), dec_rs1, tbl[i].rs1);
      chk($sformatf("r%0d dec_rs2", i), dec_rs2, tbl[i].rs2);
      chk($sformatf("r%0d dec_rd", i), dec_rd, tbl[i].rd);
      chk($sformatf("r%0d dec_rd_we", i), dec_rd_we, tbl[i].we);
    end
    // reset in the middle of a stall
    @(negedge clk);
    fetch_pc = 0;
    fetch_inst = 32'h00500093;
    @(negedge clk);
    fetch_pc = 4;
    fetch_inst = 32'h00108133;
    @(negedge clk);
    fetch_inst = 0;
    #1;
    chk("mid-stall hazard before reset", is_data_hazard, 1);
    rst = 1'b0;
    #1;
    chk("mid-stall async hazard", is_data_hazard, 0);
    chk("mid-stall async dec_valid", dec_valid, 0);
    chk("mid-stall async dec_rd", dec_rd, 0);
    @(negedge clk);
    rst = 1'b1;
    fetch_inst = 32'h00108133;
    @(negedge clk);
    fetch_inst = 0;
    #1;
    chk("after reset scoreboard cleared", is_data_hazard, 0);
    @(negedge clk);
    #1;
    chk("after reset add issues", dec_valid, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/decode_issue.md
Name: decode_issue

Overview:
- Receiving end of the fetch→decode pipe register and the driver of the data-hazard signal that fetch consumes.
- Captures pc/inst from fetch and extracts the rs1/rs2/rd fields.
- Tracks in-flight destination registers in a depth-PIPE_DEPTH issue shift register. Asserts is_data_hazard on a RAW conflict; while it is asserted, holds the instruction and issues bubbles.
- No forwarding. Sits between fetch and the register-read/execute stage.

Parameters:
PIPE_DEPTH, 3, cycles from issue until a writer's result is architecturally visible (issue→writeback)
XLEN, 32, pc/instruction width

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  asynchronous, active-low reset
fetch_pc  in  XLEN  pc from fetch pipe register
fetch_inst  in  XLEN  instruction from fetch; 32'h0 = NOP bubble
is_data_hazard  out  1  combinational; high = fetch must hold pc and resend
dec_valid  out  1  registered; issued slot holds a real instruction
dec_pc  out  XLEN  registered pc of issued instruction
dec_inst  out  XLEN  registered raw instruction
dec_rs1  out  5  source reg 1 (0 if unused)
dec_rs2  out  5  source reg 2 (0 if unused)
dec_rd  out  5  destination reg (0 if none)
dec_rd_we  out  1  issued instruction writes dec_rd

Behaviour:
- Reset (rst==0, async):
  - Input register in_pc/in_inst = 0.
  - All scoreboard entries invalid.
  - dec_* = 0, dec_valid = 0.
  - is_data_hazard therefore 0.
- Field use, by opcode inst[6:0]:
  - rs1 = inst[19:15], used unless opcode is LUI 0110111, AUIPC 0010111 or JAL 1101111.
  - rs2 = inst[24:20], used only for R 0110011, S 0100011 and B 1100011.
  - rd = inst[11:7], written unless opcode is S or B, or rd==0.
  - inst==0 is a bubble: no reads, no write.
  - Unused fields are reported as 0.
- Scoreboard:
  - sb[0..PIPE_DEPTH-1] of {valid, rd}, shifted every posedge.
  - sb[0] ← {dec_rd_we of the slot issued this edge, rd}; sb[PIPE_DEPTH-1] falls off.
- Hazard (combinational from in_inst and sb): is_data_hazard = any valid sb[i] whose rd == a used nonzero rs1/rs2 of in_inst.
  - x0 never hazards.
  - A bubble never hazards.
- Posedge when is_data_hazard==0:
  - dec_* ← decoded in_*, with dec_valid = (in_inst != 0).
  - in_* ← fetch_*.
- Posedge when is_data_hazard==1:
  - dec_* ← bubble (all 0) and sb[0] ← invalid.
  - in_* holds; fetch_* is ignored this edge.
- Latency: an instruction in in_* with no conflict appears on dec_* one edge later.
- Stall length: a consumer directly behind its producer stalls exactly PIPE_DEPTH cycles.
- Boundary cases:
  - rs1==rs2==conflicting rd: a single hazard, same duration.
  - Matches in several entries: the stall ends when the last one retires.
  - Writer with rd==0: never enters the scoreboard as valid.
  - Bubbles from fetch during a branch stall shift the scoreboard normally, so the stall also ages producers.
  - Reset mid-stall: hazard drops immediately (async clear).

Decomposition:
- Shared package (PipelineTypes/BasicTypes):
  - DecodeStagePipeReg, if not already there.
  - New IssuedOp struct {valid, pc, inst, rs1, rs2, rd, rd_we}.
  - Opcode localparams OP_LUI, OP_AUIPC, OP_JAL, OP_R, OP_S, OP_B.
  - RegAddr typedef (5 bits).
- One natural sub-module: issue_scoreboard. It holds the shift register and hazard compare (inputs: push valid/rd, rs1/rs2 with use flags; output: hazard).
- Field decode stays as automatic functions in decode_issue.

Test Plan:
- Reset: assert rst=0 with fetch_inst=0x00108133 → dec_valid=0, is_data_hazard=0; after release, first edge loads in_*, second edge shows dec_valid=1.
- Back-to-back RAW: addi x1,x0,5 (0x00500093) then add x2,x1,x1 (0x00108133), PIPE_DEPTH=3 → is_data_hazard high exactly 3 cycles; 3 bubbles issued; add issues on the 4th edge after addi with dec_rs1=dec_rs2=1, dec_rd=2.
- Independent stream: addi x1 then addi x3,x0,7 (0x00700193) → no hazard; consecutive dec_valid=1 with pcs 0,4.
- x0 and unused fields: addi x0,x0,0 (0x00000013) then add x5,x0,x0 (0x000002b3) → no hazard, dec_rd_we=0 for the first; lui x1 (0x000010b7) then jal x0 → no hazard.
- Distance ≥ PIPE_DEPTH: addi x1, two NOPs (0), then add x2,x1,x1 → hazard for exactly 1 cycle; with three NOPs → no hazard.
- Store/branch: sw x1,0(x2) (0x00112023) after addi x2 → hazard on rs1; sw itself leaves dec_rd_we=0 and no sb entry.
